mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares the single line-wide backing-memory port between the instruction cache (read-only) and the data cache (read and write-back). Sits between both cache miss interfaces and the memory model or controller. Serves one line transaction at a time, using round-robin grant on ties. A watchdog flags memory transactions that never complete.

Parameters:
CACHE_LINE_SIZE, 128, line width in bits for all data buses.
ADDR_WIDTH, 32, byte address width.
TIMEOUT_CYCLES, 64, maximum cycles the arbiter waits for in_mem_ready before it flags an error.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high; clears all state immediately.
in_i_read_en  in  1  I-cache line read request; held high until out_i_ready is seen.
in_i_addr  in  ADDR_WIDTH  I-cache line address.
out_i_read_data  out  CACHE_LINE_SIZE  registered line for the I-cache.
out_i_ready  out  1  one-cycle completion pulse to the I-cache.
in_d_read_en  in  1  D-cache line read (refill) request; level, held until ready.
in_d_write_en  in  1  D-cache line write-back request; level, held until ready.
in_d_addr  in  ADDR_WIDTH  D-cache line address.
in_d_write_data  in  CACHE_LINE_SIZE  D-cache write-back line.
out_d_read_data  out  CACHE_LINE_SIZE  registered line for the D-cache.
out_d_ready  out  1  one-cycle completion pulse to the D-cache.
out_mem_read_en  out  1  memory read command; held until in_mem_ready.
out_mem_write_en  out  1  memory write command; held until in_mem_ready.
out_mem_addr  out  ADDR_WIDTH  latched address of the granted request.
out_mem_write_data  out  CACHE_LINE_SIZE  latched write-back line.
in_mem_read_data  in  CACHE_LINE_SIZE  memory read line; valid in the cycle in_mem_ready is high.
in_mem_ready  in  1  memory completion pulse.
out_grant  out  2  current owner: 00 none, 01 I, 10 D.
out_error  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant = I, watchdog counter 0.
- States: IDLE, BUSY, RESP.
- IDLE: arbitration is evaluated each cycle on registered request levels.
  - Only I requesting: grant I.
  - Only D requesting: grant D.
  - Both requesting: grant the requester that is not last_grant. After reset D therefore wins the first tie.
- On grant (IDLE->BUSY, at the edge):
  - Latch addr and write_data into out_mem_addr and out_mem_write_data.
  - Set out_mem_read_en or out_mem_write_en.
  - Set out_grant and update last_grant.
  - Clear the watchdog.
- D-cache command selection: if in_d_write_en and in_d_read_en are both high, the grant is a write. The read stays pending and is re-arbitrated later.
- BUSY: memory outputs are held stable. Requester inputs are ignored; they must not change the latched command. The watchdog increments each cycle.
- BUSY, in_mem_ready high at edge N:
  - Clear out_mem_read_en and out_mem_write_en.
  - For a read, capture in_mem_read_data into the owner's out_*_read_data.
  - Pulse the owner's out_*_ready during cycle N+1.
  - Go to RESP.
- RESP: lasts exactly one cycle. No grant is issued, so the requester can drop its level request before IDLE samples it. RESP->IDLE unconditionally. out_grant returns to 00 on leaving RESP.
- Latency:
  - Grant at the first edge after the request is seen in IDLE.
  - Ready pulse one cycle after in_mem_ready.
  - Minimum request-to-ready time = memory latency + 2 cycles.
- Write-back completion: out_d_ready pulses; out_d_read_data is unchanged.
- Data hold: out_*_read_data holds its value until the next read completion for that requester.
- Watchdog: when the counter reaches TIMEOUT_CYCLES in BUSY:
  - Set out_error.
  - Drop the memory enables.
  - Pulse the owner's ready with read data unchanged.
  - Go to RESP.
  A late in_mem_ready in IDLE or RESP is ignored.
- Spurious in_mem_ready in IDLE: ignored; no state change.
- Reset mid-transaction: enables and grant drop asynchronously. A pending request is re-arbitrated after reset release.
- Starvation bound: with both requesters continuously requesting, grants alternate D, I, D, ...

Decomposition:
- Package mem_arbiter_pkg holds:
  - arb_state_t enum {IDLE, BUSY, RESP}.
  - req_id_t enum {REQ_NONE=2'b00, REQ_I=2'b01, REQ_D=2'b10}.
  - Constant LINE_BYTES = CACHE_LINE_SIZE/8.
- Sub-module rr_pick2: a purely combinational two-way round-robin chooser. Inputs: two request bits and last_grant. Output: the winning req_id_t.
- The FSM, latches and watchdog stay in mem_arbiter.

Test Plan:
- I-read only, memory latency 10, address 0x100:
  - out_mem_read_en and out_mem_addr=0x100 appear one edge after the request.
  - out_i_ready pulses once, 1 cycle after in_mem_ready.
  - out_i_read_data bytes are 0x00..0x0F (memory[i]=i).
- Both requesting from reset (I-read 0x200, D-read 0x300):
  - D is granted first (out_grant=10), then I.
  - Exactly one ready pulse each; no back-to-back grant without a RESP cycle.
- D write-back 0x400 with data 0xDDDD...:
  - out_mem_write_en is high until ready; memory bytes at 0x400..0x40F are updated.
  - out_d_ready pulses; out_d_read_data is unchanged.
- D read and write asserted together at 0x500:
  - The write is served first.
  - With the write dropped and the read held, a second read grant follows after RESP.
- Memory never answers, TIMEOUT_CYCLES=8:
  - out_error=1 after 8 BUSY cycles and the owner's ready pulses.
  - A later in_mem_ready is ignored; out_error stays 1 until reset.
- Reset asserted mid-BUSY:
  - Enables, grant and ready drop immediately without a clock edge.
  - After release the held request is re-granted and completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D cache line-port arbiter.
// States, requester ids and line geometry.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_I    = 2'b01,
    REQ_D    = 2'b10
  } req_id_t;

  localparam int DEF_LINE_BITS = 128;
  localparam int LINE_BYTES    = DEF_LINE_BITS / 8;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser, purely combinational.
// A tie goes to whichever requester did not win last time.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic    i_req_i,
  input  logic    d_req_i,
  input  req_id_t last_grant_i,
  output req_id_t winner_o
);

  always_comb begin
    winner_o = REQ_NONE;
    if (i_req_i && d_req_i) begin
      winner_o = (last_grant_i == REQ_I) ? REQ_D : REQ_I;
    end else if (i_req_i) begin
      winner_o = REQ_I;
    end else if (d_req_i) begin
      winner_o = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between I-cache reads and D-cache reads/write-backs.
// One transaction at a time: grant one edge after request, ready one cycle after in_mem_ready, plus a timeout watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int CACHE_LINE_SIZE = DEF_LINE_BITS,
  parameter int ADDR_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_i_read_en,
  input  logic [ADDR_WIDTH-1:0]      in_i_addr,
  output logic [CACHE_LINE_SIZE-1:0] out_i_read_data,
  output logic                       out_i_ready,
  input  logic                       in_d_read_en,
  input  logic                       in_d_write_en,
  input  logic [ADDR_WIDTH-1:0]      in_d_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_d_write_data,
  output logic [CACHE_LINE_SIZE-1:0] out_d_read_data,
  output logic                       out_d_ready,
  output logic                       out_mem_read_en,
  output logic                       out_mem_write_en,
  output logic [ADDR_WIDTH-1:0]      out_mem_addr,
  output logic [CACHE_LINE_SIZE-1:0] out_mem_write_data,
  input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,
  input  logic                       in_mem_ready,
  output logic [1:0]                 out_grant,
  output logic                       out_error
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t                 state_q, state_d;
  req_id_t                    last_q, last_d;
  req_id_t                    grant_q, grant_d;
  req_id_t                    winner;
  logic                       rd_en_q, rd_en_d;
  logic                       wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [CACHE_LINE_SIZE-1:0] wdata_q, wdata_d;
  logic [CACHE_LINE_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [CACHE_LINE_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                       i_rdy_q, i_rdy_d;
  logic                       d_rdy_q, d_rdy_d;
  logic                       err_q, err_d;
  logic [WD_W-1:0]            wdog_q, wdog_d;

  rr_pick2 u_pick (
    .i_req_i      (in_i_read_en),
    .d_req_i      (in_d_read_en | in_d_write_en),
    .last_grant_i (last_q),
    .winner_o     (winner)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    rd_en_d   = rd_en_q;
    wr_en_d   = wr_en_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_rdy_d   = 1'b0;
    d_rdy_d   = 1'b0;
    err_d     = err_q;
    wdog_d    = wdog_q;

    case (state_q)
      IDLE: begin
        if (winner != REQ_NONE) begin
          state_d = BUSY;
          grant_d = winner;
          last_d  = winner;
          wdog_d  = '0;
          if (winner == REQ_I) begin
            addr_d  = in_i_addr;
            rd_en_d = 1'b1;
          end else begin
            addr_d  = in_d_addr;
            wdata_d = in_d_write_data;
            // Write-back wins over a simultaneous refill; the refill stays pending.
            if (in_d_write_en) wr_en_d = 1'b1;
            else               rd_en_d = 1'b1;
          end
        end
      end

      BUSY: begin
        if (in_mem_ready || wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          if (!in_mem_ready) err_d = 1'b1;
          if (grant_q == REQ_I) begin
            i_rdy_d = 1'b1;
            if (in_mem_ready && rd_en_q) i_rdata_d = in_mem_read_data;
          end else begin
            d_rdy_d = 1'b1;
            if (in_mem_ready && rd_en_q) d_rdata_d = in_mem_read_data;
          end
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
        grant_d = REQ_NONE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= REQ_I;
      grant_q   <= REQ_NONE;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_rdy_q   <= 1'b0;
      d_rdy_q   <= 1'b0;
      err_q     <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_rdy_q   <= i_rdy_d;
      d_rdy_q   <= d_rdy_d;
      err_q     <= err_d;
      wdog_q    <= wdog_d;
    end
  end

  assign out_i_read_data    = i_rdata_q;
  assign out_i_ready        = i_rdy_q;
  assign out_d_read_data    = d_rdata_q;
  assign out_d_ready        = d_rdy_q;
  assign out_mem_read_en    = rd_en_q;
  assign out_mem_write_en   = wr_en_q;
  assign out_mem_addr       = addr_q;
  assign out_mem_write_data = wdata_q;
  assign out_grant          = grant_q;
  assign out_error          = err_q;

endmodule
